// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO, status, divisor and IRQ control registers.
// Optional interrupt logic is built when UART_TX_IRQ_EN is defined; otherwise tx_irq_o is tied low.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        bus_en_i,
   input  logic        bus_write_en_i,
   input  logic [3:0]  bus_write_sel_i,
   input  logic [31:0] bus_addr_i,
   input  logic [31:0] bus_write_data_i,
   output logic [31:0] bus_read_data_o,
   output logic        bus_hit_o,
   output logic        uart_txd_o,
   output logic        tx_irq_o
);
   // state   | meaning
   // S_IDLE  | line high, waiting for a queued byte
   // S_START | driving start bit (0)
   // S_DATA  | shifting 8 data bits, LSB first
   // S_STOP  | driving stop bit (1), may chain into next frame
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic [15:0]   div_q;

   state_t        state_q, state_d;
   logic [15:0]   lat_div_q, lat_div_d;
   logic [15:0]   tmr_q, tmr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          pop;

   logic          wr_acc, rd_acc, full, empty, busy, push_req, push, tmr_done;
   logic [1:0]    reg_sel;
   logic [15:0]   eff_div;
   logic [31:0]   irq_rd;
   logic          unused_bits;

   assign bus_hit_o = (bus_addr_i[31:4] == BASE_ADDR[31:4]);
   assign wr_acc    = bus_en_i & bus_write_en_i & bus_hit_o;
   assign rd_acc    = bus_en_i & ~bus_write_en_i & bus_hit_o;
   assign reg_sel   = bus_addr_i[3:2];
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign busy      = (state_q != S_IDLE);
   assign push_req  = wr_acc & (reg_sel == 2'd0) & bus_write_sel_i[0];
   assign push      = push_req & ~full;
   assign eff_div   = (div_q == 16'd0) ? 16'd1 : div_q;
   assign tmr_done  = (tmr_q == 16'd0);
   assign unused_bits = ^{bus_write_data_i[31:16], bus_write_sel_i[3:2], bus_addr_i[1:0]};

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= bus_write_data_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
         if (push_req && full)
            ovf_q <= 1'b1;
         else if (wr_acc && reg_sel == 2'd1 && bus_write_sel_i[0] && bus_write_data_i[3])
            ovf_q <= 1'b0;
         if (wr_acc && reg_sel == 2'd2) begin
            if (bus_write_sel_i[0]) div_q[7:0]  <= bus_write_data_i[7:0];
            if (bus_write_sel_i[1]) div_q[15:8] <= bus_write_data_i[15:8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         lat_div_q <= 16'd1;
         tmr_q     <= 16'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         lat_div_q <= lat_div_d;
         tmr_q     <= tmr_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_div_d = lat_div_q;
      tmr_d     = tmr_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               lat_div_d = eff_div;
               tmr_d     = eff_div - 16'd1;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (tmr_done) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tmr_d   = lat_div_q - 16'd1;
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
         S_DATA: begin
            if (tmr_done) begin
               tmr_d = lat_div_q - 16'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
         S_STOP: begin
            if (tmr_done) begin
               // chain straight into the next start bit when more data is queued
               if (!empty) begin
                  pop       = 1'b1;
                  shift_d   = mem_q[rd_ptr_q];
                  lat_div_d = eff_div;
                  tmr_d     = eff_div - 16'd1;
                  state_d   = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               tmr_d = tmr_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   assign uart_txd_o = txd_q;

`ifdef UART_TX_IRQ_EN
   logic ie_q, irq_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (wr_acc && reg_sel == 2'd3 && bus_write_sel_i[0]) ie_q <= bus_write_data_i[0];
         irq_q <= ie_q & empty & ~busy;
      end
   end
   assign tx_irq_o = irq_q;
   assign irq_rd   = {31'b0, ie_q};
`else
   assign tx_irq_o = 1'b0;
   assign irq_rd   = 32'h0;
`endif

   always_comb begin
      bus_read_data_o = 32'h0;
      if (rd_acc) begin
         case (reg_sel)
            2'd1:    bus_read_data_o = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
            2'd2:    bus_read_data_o = {16'h0, div_q};
            2'd3:    bus_read_data_o = irq_rd;
            default: bus_read_data_o = 32'h0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: bus tasks drive the register file, a serial monitor
// decodes frames off uart_txd and checks them against a queue of bytes expected on the wire.
module tb_uart_tx_mmio;
   localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_IRQ_EN
   localparam logic IRQ_BUILD = 1'b1;
`else
   localparam logic IRQ_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_en = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_sel = 4'h0;
   logic [31:0] bus_addr = 32'h0;
   logic [31:0] bus_wdata = 32'h0;
   logic [31:0] bus_rdata;
   logic        bus_hit;
   logic        txd;
   logic        irq;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mon_div = 434;
   bit          mon_active = 1'b0;
   int          mon_idx = 0;
   logic [7:0]  mon_byte = 8'h0;
   logic [7:0]  exp_q[$];
   int          starts[$];

   uart_tx_mmio dut (
      .clk_i(clk), .rst_ni(rst_n), .bus_en_i(bus_en), .bus_write_en_i(bus_we),
      .bus_write_sel_i(bus_sel), .bus_addr_i(bus_addr), .bus_write_data_i(bus_wdata),
      .bus_read_data_o(bus_rdata), .bus_hit_o(bus_hit), .uart_txd_o(txd), .tx_irq_o(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // serial monitor: samples mid-bit on falling clock edges
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active) begin
            if (txd === 1'b0) begin
               mon_active = 1'b1;
               mon_idx    = 0;
               mon_byte   = 8'h0;
               starts.push_back(cyc);
            end
         end else begin
            mon_idx++;
         end
         if (mon_active) begin
            if (mon_idx == mon_div / 2)
               check("start_bit", 32'(txd), 32'd0);
            if (mon_idx >= mon_div && mon_idx < 9 * mon_div && (mon_idx % mon_div) == mon_div / 2)
               mon_byte[(mon_idx / mon_div) - 1] = txd;
            if (mon_idx == 9 * mon_div + mon_div / 2) begin
               check("stop_bit", 32'(txd), 32'd1);
               if (exp_q.size() == 0)
                  check("unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
               else
                  check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
            end
            if (mon_idx == 10 * mon_div - 1) mon_active = 1'b0;
         end
      end
   end

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      @(negedge clk);
      bus_en = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data; bus_sel = sel;
      @(posedge clk);
      #1;
      bus_en = 1'b0; bus_we = 1'b0; bus_sel = 4'h0;
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      bus_en = 1'b1; bus_we = 1'b0; bus_addr = addr;
      #1;
      data = bus_rdata;
      bus_en = 1'b0;
   endtask

   task automatic tx_push(input logic [7:0] b, input bit accept);
      bus_wr(BASE, {24'h0, b}, 4'b0001);
      if (accept) exp_q.push_back(b);
   endtask

   task automatic set_div(input logic [15:0] d);
      bus_wr(BASE + 32'h8, {16'h0, d}, 4'b0011);
      mon_div = (d == 16'd0) ? 1 : int'(d);
   endtask

   task automatic wait_idle(input int max_reads, input string tag);
      logic [31:0] s;
      int i;
      for (i = 0; i < max_reads; i++) begin
         bus_rd(BASE + 32'h4, s);
         if (s[2] == 1'b0 && s[1] == 1'b1) break;
      end
      check(tag, 32'(i < max_reads), 32'd1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [7:0]  pat;
      int          lows;
      int          bad;

      // 1: reset values
      repeat (3) @(negedge clk);
      check("txd_in_reset", 32'(txd), 32'd1);
      rst_n = 1'b1;
      check("txd_after_reset", 32'(txd), 32'd1);
      check("irq_after_reset", 32'(irq), 32'd0);
      bus_rd(BASE + 32'h4, rd);
      check("status_reset", rd, 32'h0000_0002);
      bus_rd(BASE + 32'h8, rd);
      check("divisor_reset", rd, 32'h0000_01B2);
      bus_wr(BASE + 32'h8, 32'hABCD_0007, 4'b0001);
      bus_rd(BASE + 32'h8, rd);
      check("divisor_lane0", rd, 32'h0000_0107);

      // 2: single 0x55 frame at divisor 4, waveform cycle by cycle
      set_div(16'd4);
      bus_rd(BASE + 32'h8, rd);
      check("divisor_4", rd, 32'h0000_0004);
      tx_push(8'h55, 1'b1);
      @(negedge clk);
      check("txd_before_pop", 32'(txd), 32'd1);
      pat = 8'h55;
      for (int i = 0; i < 40; i++) begin
         logic exp_bit;
         @(negedge clk);
         if (i / 4 == 0)      exp_bit = 1'b0;
         else if (i / 4 == 9) exp_bit = 1'b1;
         else                 exp_bit = pat[i / 4 - 1];
         check($sformatf("wave_0x55[%0d]", i), 32'(txd), 32'(exp_bit));
      end
      bus_rd(BASE + 32'h4, rd);
      check("status_after_frame", rd, 32'h0000_0002);
      check("queue_drained_t2", 32'(exp_q.size()), 32'd0);

      // 3: fill FIFO at divisor 2, overflow, back-to-back frames
      set_div(16'd2);
      starts.delete();
      for (int i = 0; i < 9; i++) tx_push(8'h10 + 8'(i), 1'b1);
      bus_rd(BASE + 32'h4, rd);
      check("status_full", rd, 32'h0000_0805);
      tx_push(8'hEE, 1'b0);
      bus_rd(BASE + 32'h4, rd);
      check("status_overflow", rd, 32'h0000_080D);
      wait_idle(400, "idle_timeout_t3");
      check("queue_drained_t3", 32'(exp_q.size()), 32'd0);
      check("frame_count_t3", 32'(starts.size()), 32'd9);
      bad = 0;
      for (int i = 1; i < starts.size(); i++)
         if (starts[i] - starts[i-1] != 20) bad++;
      check("frame_gaps_t3", 32'(bad), 32'd0);
      bus_rd(BASE + 32'h4, rd);
      check("overflow_sticky", rd, 32'h0000_000A);
      bus_wr(BASE + 32'h4, 32'h0000_0008, 4'b0001);
      bus_rd(BASE + 32'h4, rd);
      check("overflow_cleared", rd, 32'h0000_0002);

      // 4: wrong byte lane, out-of-window address
      bus_wr(BASE, 32'h0000_00AA, 4'b0010);
      bus_rd(BASE + 32'h4, rd);
      check("lane1_no_push", rd, 32'h0000_0002);
      @(negedge clk);
      bus_en = 1'b1; bus_we = 1'b1; bus_addr = BASE + 32'h10; bus_wdata = 32'h33; bus_sel = 4'b0001;
      #1;
      check("hit_outside", 32'(bus_hit), 32'd0);
      @(posedge clk);
      #1;
      bus_en = 1'b0; bus_we = 1'b0; bus_sel = 4'h0;
      bus_rd(BASE + 32'h18, rd);
      check("read_outside", rd, 32'h0);
      bus_rd(BASE + 32'h4, rd);
      check("outside_no_push", rd, 32'h0000_0002);
      bus_rd(BASE, rd);
      check("txdata_reads_0", rd, 32'h0);
      repeat (30) @(negedge clk);
      check("no_frame_t4", 32'(starts.size()), 32'd9);

      // 5: reset in the middle of a frame with more bytes queued
      set_div(16'd4);
      tx_push(8'hA1, 1'b1);
      tx_push(8'hB2, 1'b1);
      tx_push(8'hC3, 1'b1);
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("txd_async_reset", 32'(txd), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      exp_q.delete();
      mon_div = 434;
      bus_rd(BASE + 32'h4, rd);
      check("status_after_rst", rd, 32'h0000_0002);
      bus_rd(BASE + 32'h8, rd);
      check("divisor_after_rst", rd, 32'h0000_01B2);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("no_frames_after_rst", 32'(lows), 32'd0);

      // 6: interrupt behaviour around a single frame at divisor 1
      set_div(16'd1);
      bus_wr(BASE + 32'hC, 32'h1, 4'b0001);
      bus_rd(BASE + 32'hC, rd);
      check("irq_ctrl_read", rd, 32'(IRQ_BUILD));
      @(negedge clk);
      check("irq_idle_ie1", 32'(irq), 32'(IRQ_BUILD));
      tx_push(8'h3C, 1'b1);
      for (int i = 0; i <= 12; i++) begin
         logic exp_irq;
         @(negedge clk);
         exp_irq = IRQ_BUILD & ((i == 0) || (i == 12));
         check($sformatf("irq_seq[%0d]", i), 32'(irq), 32'(exp_irq));
      end
      check("queue_drained_t6", 32'(exp_q.size()), 32'd0);
      bus_wr(BASE + 32'hC, 32'h0, 4'b0001);
      @(negedge clk);
      check("irq_ie0", 32'(irq), 32'd0);
      bus_rd(BASE + 32'hC, rd);
      check("irq_ctrl_cleared", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
